hv_abist_seq: RTL

Parametrised high-voltage analog BIST sequencer, the next generation of the fixed six-item HV abist.
- Walks ITEM_NUM analog checks in index order, with a per-item runtime timeout and a per-item skip mask.
- Drives one stimulus line per item and waits for the item's detect flag.
- Adds a bounded retry on timeout and a release check: detect must deassert after stimulus removal.
- Sits between the HV control/config registers and the analog front end; hands off to logic BIST via o_lbist_en when the sequence completes.

---
 rtl/hv_abist_seq.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/hv_abist_seq.sv
// hv_abist_seq: walks ITEM_NUM HV analog checks in index order, with per-item timeout, skip mask, bounded retry and a release check.
// Latency: start edge at T -> SCAN at T+1, first stimulus at T+2; every output comes straight from a flop.
// Backpressure: none; dropping i_bist_en aborts to IDLE next cycle, while fail/retry flags are held until the next start or reset.
module hv_abist_seq #(
    parameter int ITEM_NUM  = 6,
    parameter int CNT_W     = 16,
    parameter int RETRY_NUM = 1,
    parameter int GAP_CYC   = 4,
    parameter int REL_CYC   = 8,
    parameter int SEL_W     = $clog2(ITEM_NUM + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_bist_en,
    input  logic [ITEM_NUM-1:0]       i_item_mask,
    input  logic [ITEM_NUM*CNT_W-1:0] i_item_tmo,
    input  logic [ITEM_NUM-1:0]       i_det,
    output logic [ITEM_NUM-1:0]       o_bist_drv,
    output logic [ITEM_NUM-1:0]       o_bist_fail,
    output logic [ITEM_NUM-1:0]       o_bist_retry,
    output logic [SEL_W-1:0]          o_cur_item,
    output logic                      o_bist_busy,
    output logic                      o_bist_done,
    output logic                      o_lbist_en
);

    // Retry counter is at least one bit wide so RETRY_NUM=0 still elaborates.
    localparam int RT_W = (RETRY_NUM < 1) ? 1 : $clog2(RETRY_NUM + 1);

    // The gap counter runs 0..GAP_CYC, so stimulus stays off for the entry
    // cycle plus GAP_CYC counted cycles before the next attempt.
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC);
    localparam logic [CNT_W-1:0] REL_MAX   = CNT_W'(REL_CYC);
    localparam logic [RT_W-1:0]  RETRY_MAX = RT_W'(RETRY_NUM);
    localparam logic [SEL_W-1:0] SEL_END   = SEL_W'(ITEM_NUM);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SCAN    = 3'd1,
        ST_DRIVE   = 3'd2,
        ST_GAP     = 3'd3,
        ST_RELEASE = 3'd4,
        ST_NEXT    = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RT_W-1:0]      retry_cnt_q, retry_cnt_d;
    logic                 bist_en_q, bist_en_d;
    logic [ITEM_NUM-1:0]  drv_q, drv_d;
    logic [ITEM_NUM-1:0]  fail_q, fail_d;
    logic [ITEM_NUM-1:0]  retry_flag_q, retry_flag_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Per-item views of the current selection
    logic [ITEM_NUM-1:0]  sel_oh;
    logic                 mask_cur;
    logic                 det_cur;
    logic [CNT_W-1:0]     tmo_cur;

    logic                 start_edge;
    logic                 tmo_hit;
    logic                 retry_ok;
    logic                 rel_hit;
    logic                 gap_end;

    // Decode the selected item: one-hot, its mask bit, detect flag and timeout.
    // sel==ITEM_NUM matches nothing, so all views read as zero there.
    always_comb begin
        sel_oh   = '0;
        mask_cur = 1'b0;
        det_cur  = 1'b0;
        tmo_cur  = '0;
        for (int k = 0; k < ITEM_NUM; k++) begin
            if (sel_q == SEL_W'(k)) begin
                sel_oh[k] = 1'b1;
                mask_cur  = i_item_mask[k];
                det_cur   = i_det[k];
                tmo_cur   = i_item_tmo[k*CNT_W +: CNT_W];
            end
        end
    end

    // Shared compare points; the counter stops at these, it never wraps.
    always_comb begin
        start_edge = i_bist_en & ~bist_en_q;
        tmo_hit    = (cnt_q >= tmo_cur);
        retry_ok   = (retry_cnt_q < RETRY_MAX);
        rel_hit    = (cnt_q >= REL_MAX);
        gap_end    = (cnt_q == GAP_LAST);
    end

    // Register all state, datapath and output flops
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            cnt_q        <= '0;
            retry_cnt_q  <= '0;
            bist_en_q    <= 1'b0;
            drv_q        <= '0;
            fail_q       <= '0;
            retry_flag_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            retry_cnt_q  <= retry_cnt_d;
            bist_en_q    <= bist_en_d;
            drv_q        <= drv_d;
            fail_q       <= fail_d;
            retry_flag_q <= retry_flag_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Next-state: dropping the enable wins over every sequencing decision
    always_comb begin
        state_d = state_q;
        if (!i_bist_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        state_d = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (sel_q == SEL_END) begin
                        state_d = ST_DONE;
                    end else if (!mask_cur) begin
                        state_d = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    // Detect beats a timeout landing in the same cycle
                    if (det_cur) begin
                        state_d = ST_RELEASE;
                    end else if (tmo_hit) begin
                        state_d = retry_ok ? ST_GAP : ST_NEXT;
                    end
                end
                ST_GAP: begin
                    if (gap_end) begin
                        state_d = ST_DRIVE;
                    end
                end
                ST_RELEASE: begin
                    if (!det_cur || rel_hit) begin
                        state_d = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    state_d = ST_SCAN;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath and outputs: counter, selection, stimulus and sticky flags
    always_comb begin
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        retry_cnt_d  = retry_cnt_q;
        bist_en_d    = i_bist_en;
        drv_d        = drv_q;
        fail_d       = fail_q;
        retry_flag_d = retry_flag_q;

        if (!i_bist_en) begin
            // Abort: stimulus off and position cleared, flags kept for readback
            sel_d       = '0;
            cnt_d       = '0;
            retry_cnt_d = '0;
            drv_d       = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        sel_d        = '0;
                        fail_d       = '0;
                        retry_flag_d = '0;
                    end
                end
                ST_SCAN: begin
                    if (sel_q != SEL_END) begin
                        if (mask_cur) begin
                            sel_d = sel_q + SEL_W'(1);
                        end else begin
                            cnt_d       = '0;
                            retry_cnt_d = '0;
                            drv_d       = sel_oh;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (det_cur) begin
                        drv_d = '0;
                        cnt_d = '0;
                    end else if (tmo_hit && retry_ok) begin
                        retry_cnt_d  = retry_cnt_q + RT_W'(1);
                        retry_flag_d = retry_flag_q | sel_oh;
                        drv_d        = '0;
                        cnt_d        = '0;
                    end else if (tmo_hit) begin
                        fail_d = fail_q | sel_oh;
                        drv_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_end) begin
                        cnt_d = '0;
                        drv_d = sel_oh;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // Detect must let go after stimulus removal; a stuck flag fails the item
                    if (det_cur && rel_hit) begin
                        fail_d = fail_q | sel_oh;
                    end else if (det_cur) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_NEXT: begin
                    sel_d = sel_q + SEL_W'(1);
                end
                default: begin
                    drv_d = '0;
                end
            endcase
        end
    end

    // Status flags follow the state being entered so they are registered
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            ST_SCAN, ST_DRIVE, ST_GAP, ST_RELEASE, ST_NEXT: busy_d = 1'b1;
            ST_DONE:                                        done_d = 1'b1;
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    assign o_bist_drv   = drv_q;
    assign o_bist_fail  = fail_q;
    assign o_bist_retry = retry_flag_q;
    assign o_cur_item   = sel_q;
    assign o_bist_busy  = busy_q;
    assign o_bist_done  = done_q;
    // Logic BIST is handed off on completion whatever the analog result
    assign o_lbist_en   = done_q;

endmodule
